// File: rtl/chmem_pkg.sv
// Shared state encoding and default sizing for the channel-memory sequencer.
package chmem_pkg;

  localparam int CHMEM_ADD_WIDTH  = 10;
  localparam int CHMEM_MEM_SIZE   = 1024;
  localparam int CHMEM_PASS_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } chmem_state_e;

endpackage

// File: rtl/chmem_cnt.sv
// Up-counter with synchronous clear and a terminal-count compare against a run-time limit.
module chmem_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Count register; reset and clear take priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == term);

endmodule

// File: rtl/chmem_seq_ctrl.sv
// Loads a job into the channel memory, then replays it a configurable number of passes.
// Defining CHMEM_SEQ_CTRL_ERR_EN adds a sticky err status output.
module chmem_seq_ctrl
  import chmem_pkg::*;
#(
  parameter int ADD_WIDTH  = CHMEM_ADD_WIDTH,
  parameter int MEM_SIZE   = CHMEM_MEM_SIZE,
  parameter int PASS_WIDTH = CHMEM_PASS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH:0]    cfg_len,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic                  wr_inc,
  output logic                  wr_clr,
  output logic                  rd_en,
  output logic                  rd_inc,
  output logic                  rd_clr,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef CHMEM_SEQ_CTRL_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int CW = ADD_WIDTH + 1;
  localparam logic [CW-1:0] MEM_SIZE_C = CW'(MEM_SIZE);

  chmem_state_e          state_r;
  logic [CW-1:0]         len_r;
  logic [PASS_WIDTH-1:0] passes_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic                  busy_r;
  logic                  done_r;

  logic [CW-1:0]         len_clamp_s;
  logic [PASS_WIDTH-1:0] passes_eff_s;
  logic                  accept_s;
  logic                  wr_tc_s;
  logic                  rd_tc_s;
  logic                  pass_tc_s;
  logic                  in_ready_s;
  logic                  wr_en_s;
  logic                  wr_inc_s;
  logic                  wr_clr_s;
  logic                  rd_en_s;
  logic                  rd_inc_s;
  logic                  rd_clr_s;

  assign len_clamp_s  = (cfg_len > MEM_SIZE_C) ? MEM_SIZE_C : cfg_len;
  assign passes_eff_s = (cfg_passes == {PASS_WIDTH{1'b0}}) ? PASS_WIDTH'(1) : cfg_passes;
  assign accept_s     = (state_r == ST_IDLE) & start;

  // Memory and handshake controls decoded from the registered state; reset forces both pointers clear.
  always_comb begin
    in_ready_s = 1'b0;
    wr_en_s    = 1'b0;
    wr_inc_s   = 1'b0;
    wr_clr_s   = 1'b0;
    rd_en_s    = 1'b0;
    rd_inc_s   = 1'b0;
    rd_clr_s   = 1'b0;
    if (rst) begin
      wr_clr_s = 1'b1;
      rd_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            wr_clr_s = 1'b1;
            rd_clr_s = 1'b1;
          end else begin
            wr_clr_s = 1'b0;
            rd_clr_s = 1'b0;
          end
        end
        ST_LOAD: begin
          in_ready_s = 1'b1;
          wr_en_s    = in_valid;
          wr_inc_s   = in_valid;
        end
        ST_READ: begin
          rd_en_s  = 1'b1;
          rd_inc_s = 1'b1;
        end
        ST_DRAIN: begin
          rd_en_s  = 1'b1;
          rd_clr_s = 1'b1;
        end
        ST_DONE: begin
          in_ready_s = 1'b0;
        end
        default: begin
          in_ready_s = 1'b0;
        end
      endcase
    end
  end

  chmem_cnt #(.W(CW)) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s),
    .inc  (wr_en_s),
    .term (len_r - CW'(1)),
    .tc   (wr_tc_s)
  );

  // The read counter rewinds in DRAIN so each pass starts from address 0.
  chmem_cnt #(.W(CW)) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s | (state_r == ST_DRAIN)),
    .inc  (state_r == ST_READ),
    .term (len_r - CW'(1)),
    .tc   (rd_tc_s)
  );

  chmem_cnt #(.W(PASS_WIDTH)) u_pass_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s),
    .inc  (state_r == ST_DRAIN),
    .term (passes_r - PASS_WIDTH'(1)),
    .tc   (pass_tc_s)
  );

  // Job sequencing with registered busy/done status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      len_r    <= {CW{1'b0}};
      passes_r <= {PASS_WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r    <= len_clamp_s;
            passes_r <= passes_eff_s;
            busy_r   <= 1'b1;
            if (len_clamp_s == {CW{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (wr_en_s && wr_tc_s) begin
            state_r <= ST_READ;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_READ: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (rd_tc_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_READ;
          end
        end
        ST_DRAIN: begin
          busy_r <= 1'b1;
          if (pass_tc_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_READ;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Memory data_out is registered, so valid/last trail the READ address by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= (state_r == ST_READ);
      out_last_r  <= (state_r == ST_READ) & rd_tc_s & pass_tc_s;
    end
  end

`ifdef CHMEM_SEQ_CTRL_ERR_EN
  logic err_r;

  // Sticky error: bad length at an accepted start, or start while a job runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= (cfg_len == {CW{1'b0}}) | (cfg_len > MEM_SIZE_C);
    end else if (start && busy_r) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

  assign in_ready  = in_ready_s;
  assign wr_en     = wr_en_s;
  assign wr_inc    = wr_inc_s;
  assign wr_clr    = wr_clr_s;
  assign rd_en     = rd_en_s;
  assign rd_inc    = rd_inc_s;
  assign rd_clr    = rd_clr_s;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: doc/chmem_seq_ctrl.md
CHMEM_SEQ_CTRL -- requirements
Module: chmem_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ADD_WIDTH, 10, channel-memory address width.
- MEM_SIZE, 1024, channel-memory depth.
- PASS_WIDTH, 8, width of the replay-pass count.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- `clk`, in, 1, clock.
- `rst`, in, 1, synchronous active-high reset.
- `start`, in, 1, begin a job; sampled in IDLE only.
- `cfg_len`, in, ADD_WIDTH+1, words to load per job; latched at start.
- `cfg_passes`, in, PASS_WIDTH, read replays per job; latched at start; 0 is treated as 1.
- `in_valid`, in, 1, upstream word valid.
- `in_ready`, out, 1, controller accepts a word.
- `wr_en`, `wr_inc`, `wr_clr`, out, 1 each, memory write controls.
- `rd_en`, `rd_inc`, `rd_clr`, out, 1 each, memory read controls.
- `out_valid`, out, 1, memory data_out holds a valid word this cycle.
- `out_last`, out, 1, last word of the last pass.
- `busy`, out, 1, state is not IDLE.
- `done`, out, 1, one-cycle job-complete pulse.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, READ, DRAIN and DONE, encoded in a registered state.
- IDLE: on `start`, go to LOAD (or to DONE if the latched length is 0).
- LOAD: after `cfg_len` write handshakes, go to READ.
- READ: after `len` read cycles, go to DRAIN.
- DRAIN: if passes remain, go to READ; otherwise go to DONE.
- DONE: go to IDLE after one cycle.

REQ-005 In IDLE, the cycle in which `start`=1 SHALL drive `wr_clr`=1 and `rd_clr`=1 combinationally, so both memory pointers are 0 on entry to LOAD.
REQ-006 `in_ready` SHALL equal (state==LOAD).
- `wr_en` SHALL equal `in_valid` & `in_ready`.
- `wr_inc` SHALL be 1 whenever `wr_en`=1.
- One word is written per handshake; upstream stalls are allowed.

REQ-007 A write counter SHALL count handshakes. The handshake that makes count==len SHALL move the FSM to READ in the next cycle.
REQ-008 In READ, the block SHALL drive `rd_en`=1, `rd_inc`=1 and `rd_clr`=0 for exactly len consecutive cycles (addresses 0..len-1).
REQ-009 DRAIN SHALL last exactly one cycle with `rd_en`=1, `rd_clr`=1 and `rd_inc`=0.
- This exposes the final registered word.
- It also rewinds `rd_ptr` to 0 for the next pass.

REQ-010 `out_valid` SHALL be a register set to 1 in the cycle after any READ cycle.
- It yields exactly len valid words per pass, at 1-cycle latency.
- Between passes, `out_valid` is low for one cycle (the first READ cycle).

REQ-011 `out_last` SHALL be asserted together with `out_valid` for the word read from address len-1 on the final pass.
REQ-012 `done` SHALL be high for exactly the single DONE cycle. `busy` SHALL be 0 only in IDLE.
REQ-013 `start` SHALL be ignored outside IDLE.
REQ-014 A `cfg_len` greater than MEM_SIZE SHALL be clamped to MEM_SIZE.
REQ-015 All other memory-control outputs not listed as asserted SHALL be 0 in every state.
REQ-016 Counters SHALL be sized so that they never wrap:
- ADD_WIDTH+1 bits for the write and read counters.
- PASS_WIDTH bits for the pass counter.

Reset
REQ-017 `rst` SHALL force state=IDLE, clear all counters and the latched configuration, and drive `out_valid`=0, `out_last`=0 and `done`=0 in the next cycle.
REQ-018 While `rst`=1, the block SHALL drive `wr_clr`=1 and `rd_clr`=1 so the memory pointers are reset too. Reset mid-job SHALL abandon the job with no `done` pulse.

Configuration
REQ-019 The macro CHMEM_SEQ_CTRL_ERR_EN SHALL control an error-status feature as follows.
- When the macro is defined:
  - The block adds output `err` (1 bit, sticky, cleared by `rst` or by an accepted `start`).
  - `err` is set on `cfg_len`==0 at start.
  - `err` is set on `cfg_len`>MEM_SIZE at start.
  - `err` is set on `start`=1 while `busy`=1.
- When the macro is undefined, the `err` port is absent and the behaviour is otherwise identical.

Structure
REQ-020 A shared package chmem_pkg SHALL hold the FSM state encoding constants and the default ADD_WIDTH, MEM_SIZE and PASS_WIDTH values.
REQ-021 The block SHALL use one sub-module, chmem_cnt: a width-parameterised counter with clr, inc and terminal-count compare. It is instantiated three times (write, read, pass).

Verification
REQ-022 The bench SHALL cover these directed scenarios, each with `chmem_seq_ctrl` connected to the channel memory:
- Load and single pass: len=4, passes=1, data 1,2,3,4 with `in_valid` held high → `out_valid` for 4 cycles showing 1,2,3,4, `out_last` on 4, `done` 1 cycle later.
- Upstream stall: len=3, passes=2, `in_valid` toggled 1,0,1,0,1 → exactly 3 writes; output 1,2,3, then a 1-cycle gap, then 1,2,3.
- Zero length: start with len=0 → next cycle DONE with `done`=1; no `wr_en`/`rd_en`. With CHMEM_SEQ_CTRL_ERR_EN defined, `err`=1.
- Clamp: len=2000 with MEM_SIZE=1024 → exactly 1024 writes and 1024 reads per pass.
- Reset mid-READ of len=8 at word 5 → next cycle IDLE, `out_valid`=0, no `done`; a new job len=2 then completes correctly.
- Start while busy: pulse `start` in LOAD → ignored and the job completes normally. With the macro defined, `err`=1.
